// File: rtl/pulse_env_reader_pkg.sv
// Shared types and constants for the pulse envelope reader: sequencer state
// encoding, default geometry and the env_word field split.
package pulse_env_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_PHASE_WIDTH    = 14;
  localparam int DEF_FREQ_WIDTH     = 24;
  localparam int DEF_ENV_ADDR_WIDTH = 12;
  localparam int DEF_ENV_LEN_WIDTH  = 12;
  localparam int DEF_MEM_LATENCY    = 2;

  // env_word = {start_addr, length}: the address field starts right above the length
  localparam int ENV_ADDR_LSB = DEF_ENV_LEN_WIDTH;

  // Control bits carried through the latency pipe: valid, first, last
  localparam int PIPE_CTRL_W = 3;

endpackage

// File: rtl/pulse_env_reader_delay_pipe.sv
// Fixed-depth register pipe used to re-align read-side control and phase/freq
// with envelope data returning from memory.
module pulse_env_reader_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/pulse_env_reader.sv
// Envelope memory read sequencer: walks start_addr..start_addr+length-1 after cstrobe
// and delivers phase/freq aligned with returned data. PULSE_ENV_READER_QUEUE_EN adds a pending slot.
module pulse_env_reader
  import pulse_env_reader_pkg::*;
#(
  parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
  parameter int FREQ_WIDTH     = DEF_FREQ_WIDTH,
  parameter int ENV_ADDR_WIDTH = DEF_ENV_ADDR_WIDTH,
  parameter int ENV_LEN_WIDTH  = DEF_ENV_LEN_WIDTH,
  parameter int ENV_WORD_WIDTH = ENV_ADDR_WIDTH + ENV_LEN_WIDTH,
  parameter int MEM_LATENCY    = DEF_MEM_LATENCY
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cstrobe,
  input  logic [ENV_WORD_WIDTH-1:0] env_word,
  input  logic [PHASE_WIDTH-1:0]    phase,
  input  logic [FREQ_WIDTH-1:0]     freq,
  output logic                      env_ren,
  output logic [ENV_ADDR_WIDTH-1:0] env_raddr,
  output logic                      out_valid,
  output logic                      out_first,
  output logic                      out_last,
  output logic [PHASE_WIDTH-1:0]    out_phase,
  output logic [FREQ_WIDTH-1:0]     out_freq,
  output logic                      busy,
  output logic                      done
);

  localparam int ADDR_LSB = ENV_LEN_WIDTH;
  localparam int PIPE_W   = PIPE_CTRL_W + PHASE_WIDTH + FREQ_WIDTH;

  logic [ENV_ADDR_WIDTH-1:0] start_addr;
  logic [ENV_LEN_WIDTH-1:0]  start_len;
  logic                      start_ok;

  assign start_addr = env_word[ADDR_LSB +: ENV_ADDR_WIDTH];
  assign start_len  = env_word[ENV_LEN_WIDTH-1:0];
  assign start_ok   = cstrobe && (start_len != '0);

  state_t                    state_p0;
  logic                      vld_p0;
  logic                      first_p0;
  logic [ENV_ADDR_WIDTH-1:0] addr_p0;
  logic [ENV_LEN_WIDTH-1:0]  cnt_p0;
  logic [FREQ_WIDTH-1:0]     freq_p0;
  logic                      final_rd;

  assign final_rd = (state_p0 == RUN) && (cnt_p0 == ENV_LEN_WIDTH'(1));

  logic                      load;
  logic [ENV_ADDR_WIDTH-1:0] load_addr;
  logic [ENV_LEN_WIDTH-1:0]  load_len;
  logic [FREQ_WIDTH-1:0]     load_freq;

`ifdef PULSE_ENV_READER_QUEUE_EN
  logic                      pend_vld;
  logic [ENV_ADDR_WIDTH-1:0] pend_addr;
  logic [ENV_LEN_WIDTH-1:0]  pend_len;
  logic [FREQ_WIDTH-1:0]     pend_freq;
  logic                      pend_store;

  // A cstrobe on the final read goes straight in only if nothing is already waiting
  assign pend_store = (state_p0 == RUN) && start_ok && !(final_rd && !pend_vld);

  always_comb begin
    load      = 1'b0;
    load_addr = start_addr;
    load_len  = start_len;
    load_freq = freq;
    if (state_p0 == IDLE) begin
      load = start_ok;
    end else if (final_rd) begin
      if (pend_vld) begin
        load      = 1'b1;
        load_addr = pend_addr;
        load_len  = pend_len;
        load_freq = pend_freq;
      end else begin
        load = start_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_len  <= '0;
      pend_freq <= '0;
    end else if (pend_store) begin
      pend_vld  <= 1'b1;
      pend_addr <= start_addr;
      pend_len  <= start_len;
      pend_freq <= freq;
    end else if (final_rd) begin
      pend_vld  <= 1'b0;
    end
  end
`else
  // Any accepted cstrobe restarts the walk, preempting a sequence in flight
  always_comb begin
    load      = start_ok;
    load_addr = start_addr;
    load_len  = start_len;
    load_freq = freq;
  end
`endif

  // Stage p0: read request to envelope memory
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_p0 <= IDLE;
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      addr_p0  <= '0;
      cnt_p0   <= '0;
      freq_p0  <= '0;
    end else if (load) begin
      state_p0 <= RUN;
      vld_p0   <= 1'b1;
      first_p0 <= 1'b1;
      addr_p0  <= load_addr;
      cnt_p0   <= load_len;
      freq_p0  <= load_freq;
    end else if (state_p0 == RUN) begin
      first_p0 <= 1'b0;
      if (final_rd) begin
        state_p0 <= IDLE;
        vld_p0   <= 1'b0;
      end else begin
        addr_p0 <= addr_p0 + 1'b1;
        cnt_p0  <= cnt_p0 - 1'b1;
      end
    end
  end

  assign env_ren   = vld_p0;
  assign env_raddr = addr_p0;
  assign busy      = (state_p0 == RUN);

  // Stage pL: re-aligned with data returning MEM_LATENCY cycles later
  logic [PIPE_W-1:0] pipe_din;
  logic [PIPE_W-1:0] pipe_dout;

  assign pipe_din = {vld_p0, first_p0, final_rd, phase, freq_p0};

  pulse_env_reader_delay_pipe #(
    .WIDTH (PIPE_W),
    .DEPTH (MEM_LATENCY)
  ) u_delay_pipe (
    .clk  (clk),
    .rstn (rstn),
    .din  (pipe_din),
    .dout (pipe_dout)
  );

  assign {out_valid, out_first, out_last, out_phase, out_freq} = pipe_dout;
  assign done = out_valid & out_last;

endmodule
